// File: rtl/iic_arbiter.sv
// iic_arbiter: round-robin arbiter that shares one IIC EEPROM controller
// between two requesters (A and B). One transaction is in flight at a time.
// Each transaction is issued with a single start pulse and guarded by a
// timeout. A write is followed by a recovery gap that covers the EEPROM
// internal write time.

module iic_arbiter #(
   parameter int unsigned TIMEOUT_CYC = 100_000,
   parameter int unsigned WR_GAP_CYC  = 250_000
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic        a_req,
   input  logic        b_req,
   input  logic        a_wr,
   input  logic        b_wr,
   input  logic        a_add_bit,
   input  logic        b_add_bit,
   input  logic [15:0] a_word_add,
   input  logic [15:0] b_word_add,
   input  logic [7:0]  a_wr_data,
   input  logic [7:0]  b_wr_data,
   output logic        a_ack,
   output logic        b_ack,
   output logic        a_err,
   output logic        b_err,
   output logic [7:0]  a_rd_data,
   output logic [7:0]  b_rd_data,
   output logic        iic_wr_en,
   output logic        iic_rd_en,
   output logic        iic_add_bit,
   output logic [15:0] iic_word_add,
   output logic [7:0]  iic_wr_data,
   input  logic [7:0]  iic_rd_data,
   input  logic        iic_done
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_ISSUE = 3'd1;
   localparam logic [2:0] ST_WAIT  = 3'd2;
   localparam logic [2:0] ST_RESP  = 3'd3;
   localparam logic [2:0] ST_GAP   = 3'd4;

   localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYC - 1);
   localparam logic [31:0] GAP_LAST     = 32'(WR_GAP_CYC - 1);

   logic [2:0]  state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic        last_q, last_d;
   logic        owner_q, owner_d;
   logic        wr_q, wr_d;
   logic        err_q, err_d;
   logic        add_bit_q, add_bit_d;
   logic [15:0] word_add_q, word_add_d;
   logic [7:0]  wr_data_q, wr_data_d;
   logic [7:0]  a_rd_q, a_rd_d;
   logic [7:0]  b_rd_q, b_rd_d;
   logic        grant_b;

   // Pick the winner. last_q=1 means B was served last, so a tie goes to A.
   always_comb begin
      grant_b = b_req & (~a_req | ~last_q);
   end

   // Next-state logic. Fields are latched only in IDLE. The shared counter
   // times the WAIT window and the post-write GAP, and is cleared on entry to each.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      last_d     = last_q;
      owner_d    = owner_q;
      wr_d       = wr_q;
      err_d      = err_q;
      add_bit_d  = add_bit_q;
      word_add_d = word_add_q;
      wr_data_d  = wr_data_q;
      a_rd_d     = a_rd_q;
      b_rd_d     = b_rd_q;
      case (state_q)
         ST_IDLE: begin
            if (a_req || b_req) begin
               owner_d    = grant_b;
               last_d     = grant_b;
               wr_d       = grant_b ? b_wr       : a_wr;
               add_bit_d  = grant_b ? b_add_bit  : a_add_bit;
               word_add_d = grant_b ? b_word_add : a_word_add;
               wr_data_d  = grant_b ? b_wr_data  : a_wr_data;
               state_d    = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            cnt_d   = '0;
            err_d   = 1'b0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (iic_done) begin
               err_d   = 1'b0;
               state_d = ST_RESP;
               if (!wr_q) begin
                  if (owner_q) b_rd_d = iic_rd_data;
                  else         a_rd_d = iic_rd_data;
               end
            end else if (cnt_q == TIMEOUT_LAST) begin
               err_d   = 1'b1;
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         ST_RESP: begin
            cnt_d = '0;
            if (wr_q && !err_q) state_d = ST_GAP;
            else                state_d = ST_IDLE;
         end
         ST_GAP: begin
            if (cnt_q == GAP_LAST) state_d = ST_IDLE;
            else                   cnt_d = cnt_q + 32'd1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State registers. Reset aborts any transaction silently and clears every latch.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         last_q     <= 1'b1;
         owner_q    <= 1'b0;
         wr_q       <= 1'b0;
         err_q      <= 1'b0;
         add_bit_q  <= 1'b0;
         word_add_q <= '0;
         wr_data_q  <= '0;
         a_rd_q     <= '0;
         b_rd_q     <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         last_q     <= last_d;
         owner_q    <= owner_d;
         wr_q       <= wr_d;
         err_q      <= err_d;
         add_bit_q  <= add_bit_d;
         word_add_q <= word_add_d;
         wr_data_q  <= wr_data_d;
         a_rd_q     <= a_rd_d;
         b_rd_q     <= b_rd_d;
      end
   end

   assign iic_wr_en    = (state_q == ST_ISSUE) &  wr_q;
   assign iic_rd_en    = (state_q == ST_ISSUE) & ~wr_q;
   assign iic_add_bit  = add_bit_q;
   assign iic_word_add = word_add_q;
   assign iic_wr_data  = wr_data_q;
   assign a_ack        = (state_q == ST_RESP) & ~owner_q;
   assign b_ack        = (state_q == ST_RESP) &  owner_q;
   assign a_err        = a_ack & err_q;
   assign b_err        = b_ack & err_q;
   assign a_rd_data    = a_rd_q;
   assign b_rd_data    = b_rd_q;

endmodule

// File: tb/tb_iic_arbiter.sv
// tb_iic_arbiter: scoreboard bench for iic_arbiter with a short timeout and a short gap.
// The bench plays the IIC controller by driving iic_done and iic_rd_data directly.

module tb_iic_arbiter;

   localparam int TO  = 20;
   localparam int GAP = 10;

   logic        sys_clk, sys_rst;
   logic        a_req, b_req, a_wr, b_wr, a_add_bit, b_add_bit;
   logic [15:0] a_word_add, b_word_add;
   logic [7:0]  a_wr_data, b_wr_data;
   logic        a_ack, b_ack, a_err, b_err;
   logic [7:0]  a_rd_data, b_rd_data;
   logic        iic_wr_en, iic_rd_en, iic_add_bit;
   logic [15:0] iic_word_add;
   logic [7:0]  iic_wr_data, iic_rd_data;
   logic        iic_done;

   typedef struct {
      bit         owner;
      bit         err;
      logic [7:0] rd;
      int         ack_cyc;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        e;
   int          cyc;
   int          tests_run, tests_failed;
   logic [7:0]  a_rd_m, b_rd_m;

   iic_arbiter #(.TIMEOUT_CYC(TO), .WR_GAP_CYC(GAP)) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst),
      .a_req(a_req), .b_req(b_req), .a_wr(a_wr), .b_wr(b_wr),
      .a_add_bit(a_add_bit), .b_add_bit(b_add_bit),
      .a_word_add(a_word_add), .b_word_add(b_word_add),
      .a_wr_data(a_wr_data), .b_wr_data(b_wr_data),
      .a_ack(a_ack), .b_ack(b_ack), .a_err(a_err), .b_err(b_err),
      .a_rd_data(a_rd_data), .b_rd_data(b_rd_data),
      .iic_wr_en(iic_wr_en), .iic_rd_en(iic_rd_en), .iic_add_bit(iic_add_bit),
      .iic_word_add(iic_word_add), .iic_wr_data(iic_wr_data),
      .iic_rd_data(iic_rd_data), .iic_done(iic_done)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   initial cyc = 0;
   always @(posedge sys_clk) cyc <= cyc + 1;

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, required finish before 1 ms");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic step();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic do_reset();
      sys_rst = 1'b1; a_req = 1'b0; b_req = 1'b0; iic_done = 1'b0;
      step();
      step();
      sys_rst = 1'b0;
   endtask

   task automatic wait_resp(input int budget, output bit seen, output int at,
                            output bit own, output bit er, output logic [7:0] rd);
      seen = 1'b0; at = -1; own = 1'b0; er = 1'b0; rd = '0;
      for (int k = 0; k <= budget; k++) begin
         if (k > 0) step();
         if (a_ack || b_ack) begin
            seen = 1'b1; at = cyc; own = b_ack;
            er = b_ack ? b_err : a_err;
            rd = b_ack ? b_rd_data : a_rd_data;
            break;
         end
      end
   endtask

   task automatic wait_pulse(input int budget, output bit seen, output int at);
      seen = 1'b0; at = -1;
      for (int k = 0; k <= budget; k++) begin
         if (k > 0) step();
         if (iic_wr_en || iic_rd_en) begin
            seen = 1'b1; at = cyc;
            break;
         end
      end
   endtask

   task automatic test_reset();
      sys_rst = 1'b1;
      a_req = 0; b_req = 0; a_wr = 0; b_wr = 0; a_add_bit = 0; b_add_bit = 0;
      a_word_add = '0; b_word_add = '0; a_wr_data = '0; b_wr_data = '0;
      iic_done = 0; iic_rd_data = '0;
      step();
      step();
      tests_run++; if ({a_ack, b_ack, a_err, b_err} !== 4'b0) begin tests_failed++; $display("[TB] FAIL reset_ack: got %b required 0000", {a_ack, b_ack, a_err, b_err}); end
      tests_run++; if ({a_rd_data, b_rd_data} !== 16'h0) begin tests_failed++; $display("[TB] FAIL reset_rd: got %h required 0000", {a_rd_data, b_rd_data}); end
      tests_run++; if ({iic_wr_en, iic_rd_en, iic_add_bit, iic_word_add, iic_wr_data} !== 27'h0) begin tests_failed++; $display("[TB] FAIL reset_iic: got %h required 0", {iic_wr_en, iic_rd_en, iic_add_bit, iic_word_add, iic_wr_data}); end
      sys_rst = 1'b0;
      a_rd_m = '0; b_rd_m = '0;
   endtask

   task automatic test_read();
      int c0, at; bit seen, own, er; logic [7:0] rd;
      c0 = cyc;
      a_req = 1; a_wr = 0; a_word_add = 16'h0012; a_add_bit = 0; a_wr_data = 8'hEE;
      step();
      tests_run++; if ({iic_wr_en, iic_rd_en} !== 2'b01) begin tests_failed++; $display("[TB] FAIL read_start: wr/rd_en=%b required 01", {iic_wr_en, iic_rd_en}); end
      tests_run++; if ({iic_add_bit, iic_word_add} !== {1'b0, 16'h0012}) begin tests_failed++; $display("[TB] FAIL read_latch: got %h required 00012", {iic_add_bit, iic_word_add}); end
      a_rd_m = 8'h5A;
      exp_q.push_back('{1'b0, 1'b0, a_rd_m, c0 + 7});
      repeat (5) step();
      iic_done = 1; iic_rd_data = 8'h5A;
      step();
      iic_done = 0; a_req = 0;
      wait_resp(3, seen, at, own, er, rd);
      e = exp_q.pop_front();
      tests_run++; if (!seen || own !== e.owner || er !== e.err || rd !== e.rd || at !== e.ack_cyc) begin tests_failed++; $display("[TB] FAIL read_resp: seen=%0b own=%0b err=%0b rd=%h cyc=%0d required own=%0b err=%0b rd=%h cyc=%0d", seen, own, er, rd, at, e.owner, e.err, e.rd, e.ack_cyc); end
      step();
      step();
      tests_run++; if ({a_ack, b_ack, iic_wr_en, iic_rd_en} !== 4'b0) begin tests_failed++; $display("[TB] FAIL read_idle: got %b required 0000", {a_ack, b_ack, iic_wr_en, iic_rd_en}); end
   endtask

   task automatic test_timeout();
      int pc, at; bit seen, own, er; logic [7:0] rd;
      a_req = 1; a_wr = 0; a_word_add = 16'h0034;
      step();
      tests_run++; if ({iic_wr_en, iic_rd_en} !== 2'b01) begin tests_failed++; $display("[TB] FAIL timeout_start: wr/rd_en=%b required 01", {iic_wr_en, iic_rd_en}); end
      pc = cyc;
      exp_q.push_back('{1'b0, 1'b1, a_rd_m, pc + TO + 1});
      wait_resp(TO + 10, seen, at, own, er, rd);
      a_req = 0;
      e = exp_q.pop_front();
      tests_run++; if (!seen || own !== e.owner || er !== e.err || rd !== e.rd || at !== e.ack_cyc) begin tests_failed++; $display("[TB] FAIL timeout_resp: seen=%0b own=%0b err=%0b rd=%h cyc=%0d required own=%0b err=%0b rd=%h cyc=%0d", seen, own, er, rd, at, e.owner, e.err, e.rd, e.ack_cyc); end
   endtask

   task automatic test_done_boundary();
      int pc, at; bit seen, own, er, any; logic [7:0] rd;
      b_req = 1; b_wr = 0; b_add_bit = 0; b_word_add = 16'h0077;
      step();
      step();
      tests_run++; if ({iic_wr_en, iic_rd_en, iic_word_add} !== {2'b01, 16'h0077}) begin tests_failed++; $display("[TB] FAIL no_gap_after_timeout: got %h required 10077", {iic_wr_en, iic_rd_en, iic_word_add}); end
      pc = cyc;
      b_rd_m = 8'hC7;
      exp_q.push_back('{1'b1, 1'b0, b_rd_m, pc + TO + 1});
      repeat (TO) step();
      iic_done = 1; iic_rd_data = 8'hC7;
      step();
      iic_done = 0; b_req = 0;
      wait_resp(2, seen, at, own, er, rd);
      e = exp_q.pop_front();
      tests_run++; if (!seen || own !== e.owner || er !== e.err || rd !== e.rd || at !== e.ack_cyc) begin tests_failed++; $display("[TB] FAIL done_at_timeout: seen=%0b own=%0b err=%0b rd=%h cyc=%0d required own=%0b err=%0b rd=%h cyc=%0d", seen, own, er, rd, at, e.owner, e.err, e.rd, e.ack_cyc); end
      step();
      iic_done = 1; iic_rd_data = 8'hFF;
      step();
      iic_done = 0;
      any = 0;
      repeat (3) begin
         if (a_ack || b_ack || iic_wr_en || iic_rd_en) any = 1;
         step();
      end
      tests_run++; if (any !== 1'b0) begin tests_failed++; $display("[TB] FAIL stray_done: activity=%0b required 0", any); end
      tests_run++; if ({a_rd_data, b_rd_data} !== {a_rd_m, b_rd_m}) begin tests_failed++; $display("[TB] FAIL stray_rd_hold: got %h required %h", {a_rd_data, b_rd_data}, {a_rd_m, b_rd_m}); end
   endtask

   task automatic test_write16();
      int pc, at, ack_at; bit seen, own, er, stable; logic [7:0] rd;
      b_req = 1; b_wr = 1; b_add_bit = 1; b_word_add = 16'hA5C3; b_wr_data = 8'h3C;
      step();
      tests_run++; if ({iic_wr_en, iic_rd_en} !== 2'b10) begin tests_failed++; $display("[TB] FAIL w16_start: wr/rd_en=%b required 10", {iic_wr_en, iic_rd_en}); end
      tests_run++; if ({iic_add_bit, iic_word_add, iic_wr_data} !== {1'b1, 16'hA5C3, 8'h3C}) begin tests_failed++; $display("[TB] FAIL w16_fields: got %h required 1a5c33c", {iic_add_bit, iic_word_add, iic_wr_data}); end
      pc = cyc;
      b_add_bit = 0; b_word_add = 16'h0000; b_wr_data = 8'h00;
      exp_q.push_back('{1'b1, 1'b0, b_rd_m, pc + 5});
      stable = 1;
      for (int k = 0; k < 4; k++) begin
         step();
         if ({iic_add_bit, iic_word_add, iic_wr_data} !== {1'b1, 16'hA5C3, 8'h3C}) stable = 0;
      end
      iic_done = 1; iic_rd_data = 8'h99;
      step();
      iic_done = 0;
      if ({iic_add_bit, iic_word_add, iic_wr_data} !== {1'b1, 16'hA5C3, 8'h3C}) stable = 0;
      b_req = 0;
      wait_resp(2, seen, at, own, er, rd);
      e = exp_q.pop_front();
      tests_run++; if (!seen || own !== e.owner || er !== e.err || rd !== e.rd || at !== e.ack_cyc) begin tests_failed++; $display("[TB] FAIL w16_resp: seen=%0b own=%0b err=%0b rd=%h cyc=%0d required own=%0b err=%0b rd=%h cyc=%0d", seen, own, er, rd, at, e.owner, e.err, e.rd, e.ack_cyc); end
      tests_run++; if (stable !== 1'b1) begin tests_failed++; $display("[TB] FAIL w16_stable: stable=%0b required 1", stable); end
      ack_at = at;
      a_req = 1; a_wr = 0; a_add_bit = 1; a_word_add = 16'h0100;
      wait_pulse(GAP + 10, seen, pc);
      tests_run++; if (!seen || pc !== ack_at + GAP + 2 || {iic_rd_en, iic_word_add} !== {1'b1, 16'h0100}) begin tests_failed++; $display("[TB] FAIL gap_holdoff: seen=%0b cyc=%0d rd_en/addr=%h required cyc=%0d 10100", seen, pc, {iic_rd_en, iic_word_add}, ack_at + GAP + 2); end
      a_rd_m = 8'h81;
      exp_q.push_back('{1'b0, 1'b0, a_rd_m, pc + 3});
      step();
      step();
      iic_done = 1; iic_rd_data = 8'h81;
      step();
      iic_done = 0; a_req = 0;
      wait_resp(2, seen, at, own, er, rd);
      e = exp_q.pop_front();
      tests_run++; if (!seen || own !== e.owner || er !== e.err || rd !== e.rd || at !== e.ack_cyc) begin tests_failed++; $display("[TB] FAIL gap_read_resp: seen=%0b own=%0b err=%0b rd=%h cyc=%0d required own=%0b err=%0b rd=%h cyc=%0d", seen, own, er, rd, at, e.owner, e.err, e.rd, e.ack_cyc); end
   endtask

   task automatic test_reset_midwait();
      step();
      a_req = 1; a_wr = 0; a_add_bit = 0; a_word_add = 16'h0200;
      step();
      b_req = 1; b_wr = 0; b_add_bit = 0; b_word_add = 16'h0300;
      step();
      step();
      sys_rst = 1; a_req = 0;
      step();
      tests_run++; if ({a_ack, b_ack, a_err, b_err, a_rd_data, b_rd_data, iic_wr_en, iic_rd_en, iic_add_bit, iic_word_add, iic_wr_data} !== 47'h0) begin tests_failed++; $display("[TB] FAIL rst_midwait_zero: got %h required 0", {a_ack, b_ack, a_err, b_err, a_rd_data, b_rd_data, iic_wr_en, iic_rd_en, iic_add_bit, iic_word_add, iic_wr_data}); end
      sys_rst = 0;
      a_rd_m = '0; b_rd_m = '0;
      step();
      tests_run++; if ({a_ack, b_ack, iic_wr_en, iic_rd_en, iic_word_add} !== {4'b0001, 16'h0300}) begin tests_failed++; $display("[TB] FAIL rst_regrant: got %h required 10300", {a_ack, b_ack, iic_wr_en, iic_rd_en, iic_word_add}); end
      b_req = 0;
   endtask

   task automatic test_back_to_back();
      int pc, at, last_ack; bit seen, own, er, ow; logic [7:0] rd, a_d, b_d;
      do_reset();
      a_rd_m = '0; b_rd_m = '0;
      exp_q.delete();
      a_d = 8'h10; b_d = 8'h20; last_ack = 0;
      a_req = 1; b_req = 1; a_wr = 1; b_wr = 1; a_add_bit = 0; b_add_bit = 0;
      a_word_add = 16'h0040; b_word_add = 16'h0050; a_wr_data = a_d; b_wr_data = b_d;
      for (int i = 0; i < 4; i++) begin
         ow = ((i % 2) == 1);
         wait_pulse(GAP + 20, seen, pc);
         tests_run++; if (!seen || iic_wr_en !== 1'b1 || iic_wr_data !== (ow ? b_d : a_d) || iic_word_add !== (ow ? 16'h0050 : 16'h0040)) begin tests_failed++; $display("[TB] FAIL tie_grant%0d: seen=%0b wr_en=%0b data=%h addr=%h required owner %0b data=%h", i, seen, iic_wr_en, iic_wr_data, iic_word_add, ow, ow ? b_d : a_d); end
         if (i > 0) begin
            tests_run++; if (pc - last_ack !== GAP + 2) begin tests_failed++; $display("[TB] FAIL tie_gap%0d: ack-to-start=%0d required %0d", i, pc - last_ack, GAP + 2); end
         end
         exp_q.push_back('{ow, 1'b0, ow ? b_rd_m : a_rd_m, pc + 3});
         step();
         step();
         iic_done = 1; iic_rd_data = 8'hB4;
         step();
         iic_done = 0;
         wait_resp(2, seen, at, own, er, rd);
         e = exp_q.pop_front();
         tests_run++; if (!seen || own !== e.owner || er !== e.err || rd !== e.rd || at !== e.ack_cyc) begin tests_failed++; $display("[TB] FAIL tie_resp%0d: seen=%0b own=%0b err=%0b rd=%h cyc=%0d required own=%0b err=%0b rd=%h cyc=%0d", i, seen, own, er, rd, at, e.owner, e.err, e.rd, e.ack_cyc); end
         last_ack = at;
         if (ow) begin b_d = b_d + 8'd1; b_wr_data = b_d; end
         else    begin a_d = a_d + 8'd1; a_wr_data = a_d; end
      end
      a_req = 0; b_req = 0;
   endtask

   // Run every scenario in order; later tests rely on read data left by earlier ones.
   initial begin
      tests_run = 0; tests_failed = 0;
      test_reset();
      test_read();
      test_timeout();
      test_done_boundary();
      test_write16();
      test_reset_midwait();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
